// File: rtl/frame_pkg.sv
// Shared definitions for the frame transmitter/receiver pair: framing words,
// CRC-16/CCITT constants, transmitter state encoding and the layout of the
// 140-bit transmit FIFO entry.
package frame_pkg;

  localparam int unsigned WORD_W            = 16;
  localparam int unsigned ENTRY_W           = 140;
  localparam int unsigned MAX_PAYLOAD_WORDS = 8;

  // Field positions inside a FIFO entry
  localparam int unsigned LEN_MSB     = 139;
  localparam int unsigned LEN_LSB     = 136;
  localparam int unsigned CHAN_MSB    = 135;
  localparam int unsigned CHAN_LSB    = 128;
  localparam int unsigned PAYLOAD_MSB = 127;
  localparam int unsigned PAYLOAD_W   = PAYLOAD_MSB + 1;

  localparam logic [WORD_W-1:0] FRAME_HEADER_WORD = 16'hE0E0;
  localparam logic [WORD_W-1:0] FRAME_TAIL_WORD   = 16'h0E0E;
  localparam logic [WORD_W-1:0] CRC16_POLY        = 16'h1021;
  localparam logic [WORD_W-1:0] CRC16_INIT        = 16'hFFFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HEAD0,
    ST_HEAD1,
    ST_CHAN,
    ST_DATA,
    ST_CRC,
    ST_TAIL0,
    ST_TAIL1,
    ST_GAP
  } tx_state_t;

  typedef struct packed {
    logic [LEN_MSB-LEN_LSB:0]   len;
    logic [CHAN_MSB-CHAN_LSB:0] chan;
    logic [PAYLOAD_MSB:0]       payload;
  } tx_entry_t;

  // Payload word idx sits at [127-16*idx -: 16]; word 0 is the most significant
  function automatic logic [WORD_W-1:0] payload_word(input logic [PAYLOAD_W-1:0] payload,
                                                     input logic [2:0]           idx);
    logic [6:0] sh;
    sh = {3'(3'd7 - idx), 4'b0000};
    return WORD_W'(payload >> sh);
  endfunction

endpackage

// File: rtl/crc16_word.sv
// CRC-16/CCITT (poly 0x1021, MSB-first, no reflection) advanced by one
// 16-bit word per call. Purely combinational; shared with the receiver.
// Ports: crc (current register), word (data), next_crc (updated register).
module crc16_word
  import frame_pkg::*;
(
  input  logic [WORD_W-1:0] crc,
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] next_crc
);

  // Bit-serial recurrence unrolled over the 16 data bits, MSB first
  always_comb begin
    logic [WORD_W-1:0] c;
    c = crc;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (c[WORD_W-1] ^ word[i]) c = {c[WORD_W-2:0], 1'b0} ^ CRC16_POLY;
      else                       c = {c[WORD_W-2:0], 1'b0};
    end
    next_crc = c;
  end

endmodule

// File: rtl/frame_tx.sv
// Frame transmitter: pops one 140-bit entry from the transmit FIFO and
// serialises it as header(2), channel, payload(N), CRC, tail(2), then idles
// GAP_CYCLES cycles. Entries with N==0 or N>MAX_WORDS are dropped with len_err.
// Build option: FRAME_TX_CRC_EN -- when defined the CRC slot carries the
// CRC-16/CCITT over channel + payload words, otherwise it carries 16'h0000.
// Ports:
//   clk_in, rst_n     clock, async active-low reset
//   fifo_empty        upstream FIFO empty flag
//   fifo_r_enable     FIFO read strobe (combinational, IDLE only)
//   fifo_r_data       FIFO entry, valid the cycle after the strobe
//   data_out          serial frame word (registered)
//   data_valid        data_out holds a frame word (registered)
//   tx_busy           state != IDLE (registered)
//   len_err           one-cycle pulse on a dropped bad-length entry
module frame_tx
  import frame_pkg::*;
#(
  parameter int unsigned MAX_WORDS  = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               fifo_empty,
  output logic               fifo_r_enable,
  input  logic [ENTRY_W-1:0] fifo_r_data,
  output logic [WORD_W-1:0]  data_out,
  output logic               data_valid,
  output logic               tx_busy,
  output logic               len_err
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0] MAX_LEN = 4'(MAX_WORDS);

  tx_state_t         state;
  tx_entry_t         entry_in;
  tx_entry_t         hold_q;
  logic [2:0]        word_cnt;
  logic [2:0]        last_idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic              len_bad;
  logic [WORD_W-1:0] crc_slot;

  assign entry_in = tx_entry_t'(fifo_r_data);
  assign len_bad  = (entry_in.len == 4'd0) || (entry_in.len > MAX_LEN);
  assign last_idx = 3'(hold_q.len - 4'd1);

  // Gated by rst_n so the strobe stays low while reset is held
  assign fifo_r_enable = rst_n && (state == ST_IDLE) && !fifo_empty;

`ifdef FRAME_TX_CRC_EN
  logic [WORD_W-1:0] crc_q;
  logic [WORD_W-1:0] crc_next;

  // data_out already holds the covered word while in CHAN/DATA
  crc16_word u_crc (
    .crc      (crc_q),
    .word     (data_out),
    .next_crc (crc_next)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC16_INIT;
    end else if (state == ST_FETCH) begin
      crc_q <= CRC16_INIT;
    end else if (state == ST_CHAN || state == ST_DATA) begin
      crc_q <= crc_next;
    end
  end

  // On the last DATA cycle crc_next already includes the final payload word
  assign crc_slot = crc_next;
`else
  assign crc_slot = '0;
`endif

  // Frame sequencer; data_out/data_valid are loaded with the word for the state being entered
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      hold_q     <= '0;
      word_cnt   <= '0;
      gap_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      tx_busy    <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      len_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state   <= ST_FETCH;
            tx_busy <= 1'b1;
          end
        end
        ST_FETCH: begin
          hold_q <= entry_in;
          if (len_bad) begin
            len_err <= 1'b1;
            tx_busy <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            data_out   <= FRAME_HEADER_WORD;
            data_valid <= 1'b1;
            state      <= ST_HEAD0;
          end
        end
        ST_HEAD0: begin
          data_out <= FRAME_HEADER_WORD;
          state    <= ST_HEAD1;
        end
        ST_HEAD1: begin
          data_out <= {8'h00, hold_q.chan};
          state    <= ST_CHAN;
        end
        ST_CHAN: begin
          data_out <= payload_word(hold_q.payload, 3'd0);
          word_cnt <= '0;
          state    <= ST_DATA;
        end
        ST_DATA: begin
          if (word_cnt == last_idx) begin
            data_out <= crc_slot;
            state    <= ST_CRC;
          end else begin
            data_out <= payload_word(hold_q.payload, word_cnt + 3'd1);
            word_cnt <= word_cnt + 3'd1;
          end
        end
        ST_CRC: begin
          data_out <= FRAME_TAIL_WORD;
          state    <= ST_TAIL0;
        end
        ST_TAIL0: begin
          data_out <= FRAME_TAIL_WORD;
          state    <= ST_TAIL1;
        end
        ST_TAIL1: begin
          data_out   <= '0;
          data_valid <= 1'b0;
          gap_cnt    <= '0;
          state      <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            tx_busy <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          data_out   <= '0;
          data_valid <= 1'b0;
          tx_busy    <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx.sv
// Self-checking bench for frame_tx: table-driven single-frame and bad-length
// sequences, plus back-to-back maximum frames and a mid-frame reset.
// Expected CRC slot follows FRAME_TX_CRC_EN (CRC value or 16'h0000).
module tb_frame_tx;

  logic         clk_in = 1'b0;
  logic         rst_n;
  logic         fifo_empty;
  logic         fifo_r_enable;
  logic [139:0] fifo_r_data = '0;
  logic [15:0]  data_out;
  logic         data_valid;
  logic         tx_busy;
  logic         len_err;

  int n_tests = 0;
  int n_fail  = 0;

  frame_tx #(.MAX_WORDS(8), .GAP_CYCLES(1)) dut (
    .clk_in        (clk_in),
    .rst_n         (rst_n),
    .fifo_empty    (fifo_empty),
    .fifo_r_enable (fifo_r_enable),
    .fifo_r_data   (fifo_r_data),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .tx_busy       (tx_busy),
    .len_err       (len_err)
  );

  always #5 clk_in = ~clk_in;

  // Upstream FIFO model: pushes at negedge from the test, pops on read strobe
  logic [139:0] fifo_q[$];
  int push_cnt = 0;
  int pop_cnt  = 0;
  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk_in) begin
    if (fifo_r_enable && fifo_q.size() > 0) begin
      fifo_r_data <= fifo_q.pop_front();
      pop_cnt     <= pop_cnt + 1;
    end
  end

  task automatic push(input logic [139:0] e);
    fifo_q.push_back(e);
    push_cnt = push_cnt + 1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      if (r[15] ^ w[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [139:0] mk_entry(input logic [3:0] n, input logic [7:0] ch,
                                            input logic [15:0] w [8]);
    logic [139:0] e;
    e = '0;
    e[139:136] = n;
    e[135:128] = ch;
    for (int k = 0; k < 8; k++) e[127-16*k -: 16] = w[k];
    return e;
  endfunction

  // Expected valid-word stream of one frame
  logic [15:0] exp_w [16];

  task automatic build_exp(input logic [7:0] ch, input logic [15:0] w [8], input int n);
    logic [15:0] c;
    c = crc_upd(16'hFFFF, {8'h00, ch});
    exp_w[0] = 16'hE0E0;
    exp_w[1] = 16'hE0E0;
    exp_w[2] = {8'h00, ch};
    for (int k = 0; k < n; k++) begin
      exp_w[3+k] = w[k];
      c = crc_upd(c, w[k]);
    end
`ifdef FRAME_TX_CRC_EN
    exp_w[3+n] = c;
`else
    exp_w[3+n] = 16'h0000;
`endif
    exp_w[4+n] = 16'h0E0E;
    exp_w[5+n] = 16'h0E0E;
  endtask

  typedef struct {
    logic        rd_en;
    logic        busy;
    logic        valid;
    logic        lerr;
    logic [15:0] data;
  } vec_t;

  vec_t tbl_single [12];
  vec_t tbl_bad    [12];

  // Row k is cycle T+k; the caller pushes at the negedge of cycle T
  task automatic run_table(input string tag, input int n, input vec_t v [12]);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk_in);
      #1;
      check($sformatf("%s[%0d].rd_en", tag, k), 16'(fifo_r_enable), 16'(v[k].rd_en));
      check($sformatf("%s[%0d].busy",  tag, k), 16'(tx_busy),       16'(v[k].busy));
      check($sformatf("%s[%0d].valid", tag, k), 16'(data_valid),    16'(v[k].valid));
      check($sformatf("%s[%0d].lerr",  tag, k), 16'(len_err),       16'(v[k].lerr));
      check($sformatf("%s[%0d].data",  tag, k), data_out,           v[k].data);
    end
  endtask

  // Checks one frame of n words from strobe cycle T (current negedge) to first idle
  task automatic check_frame(input string tag, input int n);
    for (int k = 0; k <= n + 9; k++) begin
      if (k > 0) @(negedge clk_in);
      #1;
      check($sformatf("%s[%0d].rd_en", tag, k), 16'(fifo_r_enable), (k == 0) ? 16'd1 : 16'd0);
      if (k >= 2 && k <= n + 7) begin
        check($sformatf("%s[%0d].valid", tag, k), 16'(data_valid), 16'd1);
        check($sformatf("%s[%0d].data",  tag, k), data_out, exp_w[k-2]);
      end else begin
        check($sformatf("%s[%0d].valid", tag, k), 16'(data_valid), 16'd0);
        check($sformatf("%s[%0d].data",  tag, k), data_out, 16'h0000);
      end
    end
  endtask

  logic [15:0] w_a [8];
  logic [15:0] w_b [8];
  logic [15:0] exp_a [16];
  logic [15:0] exp_b [16];
  logic        log_rd [41];
  logic        log_v  [41];
  logic [15:0] log_d  [41];

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    #1;
    check("reset.data",  data_out,             16'h0000);
    check("reset.valid", 16'(data_valid),      16'd0);
    check("reset.busy",  16'(tx_busy),         16'd0);
    check("reset.lerr",  16'(len_err),         16'd0);
    check("reset.rd_en", 16'(fifo_r_enable),   16'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // ---- Single frame: N=2, channel 0x05, words 1234/ABCD
    w_a = '{16'h1234, 16'hABCD, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    build_exp(8'h05, w_a, 2);
    tbl_single[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl_single[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl_single[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'hE0E0};
    tbl_single[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'hE0E0};
    tbl_single[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0005};
    tbl_single[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h1234};
    tbl_single[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'hABCD};
    tbl_single[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, exp_w[5]};
    tbl_single[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0E0E};
    tbl_single[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0E0E};
    tbl_single[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl_single[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    @(negedge clk_in);
    push(mk_entry(4'd2, 8'h05, w_a));
    run_table("single", 12, tbl_single);

    // ---- Bad length: N=0 then N=9 queued together
    tbl_bad[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl_bad[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl_bad[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000};
    tbl_bad[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl_bad[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    tbl_bad[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    for (int k = 6; k < 12; k++) tbl_bad[k] = tbl_bad[5];
    w_b = '{16'hDEAD, 16'hBEEF, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6};
    @(negedge clk_in);
    push(mk_entry(4'd0, 8'h11, w_b));
    push(mk_entry(4'd9, 8'h22, w_b));
    run_table("badlen", 6, tbl_bad);

    // ---- Max length back-to-back: two N=8 entries
    for (int k = 0; k < 8; k++) begin
      w_a[k] = 16'h1000 + 16'(k);
      w_b[k] = 16'hF0F0 ^ 16'(k * 16'h0101);
    end
    build_exp(8'hA5, w_a, 8);
    exp_a = exp_w;
    build_exp(8'h3C, w_b, 8);
    exp_b = exp_w;
    @(negedge clk_in);
    push(mk_entry(4'd8, 8'hA5, w_a));
    push(mk_entry(4'd8, 8'h3C, w_b));
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) @(negedge clk_in);
      #1;
      log_rd[i] = fifo_r_enable;
      log_v[i]  = data_valid;
      log_d[i]  = data_out;
    end
    begin
      int second;
      second = -1;
      for (int i = 1; i <= 40; i++) if (log_rd[i] && second < 0) second = i;
      check("b2b.first_rd", 16'(log_rd[0]), 16'd1);
      check("b2b.rd_period", 16'(second), 16'd17);
    end
    for (int i = 0; i <= 40; i++) begin
      if (i >= 2 && i <= 15) begin
        check($sformatf("b2b[%0d].valid", i), 16'(log_v[i]), 16'd1);
        check($sformatf("b2b[%0d].data", i), log_d[i], exp_a[i-2]);
      end else if (i >= 19 && i <= 32) begin
        check($sformatf("b2b[%0d].valid", i), 16'(log_v[i]), 16'd1);
        check($sformatf("b2b[%0d].data", i), log_d[i], exp_b[i-19]);
      end else begin
        check($sformatf("b2b[%0d].valid", i), 16'(log_v[i]), 16'd0);
      end
    end

    // ---- Reset during DATA, then recovery
    for (int k = 0; k < 8; k++) w_a[k] = 16'h5500 + 16'(k);
    @(negedge clk_in);
    push(mk_entry(4'd4, 8'h77, w_a));
    repeat (6) @(negedge clk_in);
    #1;
    check("rst.pre_valid", 16'(data_valid), 16'd1);
    check("rst.pre_data",  data_out, 16'h5501);
    #1 rst_n = 1'b0;
    #1;
    check("rst.data",  data_out,           16'h0000);
    check("rst.valid", 16'(data_valid),    16'd0);
    check("rst.busy",  16'(tx_busy),       16'd0);
    check("rst.lerr",  16'(len_err),       16'd0);
    check("rst.rd_en", 16'(fifo_r_enable), 16'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      #1;
      check($sformatf("post_rst[%0d].busy", k),  16'(tx_busy),       16'd0);
      check($sformatf("post_rst[%0d].valid", k), 16'(data_valid),    16'd0);
      check($sformatf("post_rst[%0d].rd_en", k), 16'(fifo_r_enable), 16'd0);
    end
    w_b = '{16'hC001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    build_exp(8'hFF, w_b, 1);
    @(negedge clk_in);
    push(mk_entry(4'd1, 8'hFF, w_b));
    check_frame("after_rst", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_tx.md
# frame_tx

Frame transmitter and counterpart of the frame receiver. It pops one 140-bit entry from the upstream transmit FIFO and serialises it onto a 16-bit word stream: header, channel word, payload, CRC, tail. The receiver at the far end of the link consumes this stream. There is one word per clock and no downstream backpressure.

## Interface
Parameters:
- MAX_WORDS, 8: maximum payload words per frame (1..8).
- GAP_CYCLES, 1: idle cycles forced after each tail (≥1).

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  upstream FIFO empty flag.
- fifo_r_enable  output  1  FIFO read strobe; data returns the next cycle.
- fifo_r_data  input  140  FIFO entry, laid out as follows:
  - [139:136] payload length N.
  - [135:128] channel.
  - [127:0] payload; word k sits at [127-16k -: 16].
- data_out  output  16  serial frame word.
- data_valid  output  1  data_out carries a frame word.
- tx_busy  output  1  high from the read strobe through the end of the gap.
- len_err  output  1  one-cycle pulse when an entry is dropped for bad length.

## Operation
States: IDLE, FETCH, HEAD0, HEAD1, CHAN, DATA, CRC, TAIL0, TAIL1, GAP.

- **IDLE:** fifo_r_enable = !fifo_empty (combinational, IDLE only). If it is asserted, go to FETCH.
- **FETCH:** latch fifo_r_data into the holding register, then check the length.
  - If N==0 or N>MAX_WORDS: pulse len_err, emit no frame, go to IDLE.
  - Otherwise: go to HEAD0.
- **HEAD0 / HEAD1:** emit 16'hE0E0 in each.
- **CHAN:** emit {8'h00, channel}.
- **DATA:** emit payload words 0..N-1 in order. A 3-bit word counter starts at 0 and leaves the state at count N-1.
- **CRC:** emit the CRC word.
- **TAIL0 / TAIL1:** emit 16'h0E0E in each.
- **GAP:** stay GAP_CYCLES cycles with data_valid=0, then go to IDLE.

CRC rules:
- Algorithm is CRC-16/CCITT: polynomial 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR.
- Coverage is the channel word followed by the N payload words, 16 bits per cycle.
- The running CRC register is seeded to 0xFFFF in FETCH and updated as each covered word is emitted.

Output and register rules:
- Outside frame words, data_out = 16'h0000 and data_valid = 0.
- The holding register is not reloaded until the next FETCH.
- An empty FIFO causes no glitch on fifo_r_enable.
- fifo_empty changing mid-frame has no effect.

Reset values (asynchronous): state IDLE, data_out 0, data_valid 0, len_err 0, tx_busy 0, CRC register 0xFFFF, counters 0. Reset mid-frame aborts immediately. No tail is sent and the FIFO entry is lost.

## Timing
- Cycle T: IDLE with !fifo_empty, so fifo_r_enable=1.
- T+1: FETCH; fifo_r_data is valid and sampled.
- data_out and data_valid are registered.
- First header word is on data_out at T+2.
- Valid words occupy cycles T+2 .. T+N+7, i.e. N+6 contiguous valid cycles with no bubbles.
- GAP occupies T+N+8 .. T+N+7+GAP_CYCLES.
- Earliest next fifo_r_enable is the first IDLE cycle after GAP.
- With GAP_CYCLES=1, back-to-back entries give a period of N+9 cycles.
- Bad length: len_err is high at T+2 and the block is in IDLE at T+2. The next read can occur at T+2.
- tx_busy = (state != IDLE).

## Configuration
- FRAME_TX_CRC_EN defined: CRC computed and emitted as above.
- FRAME_TX_CRC_EN undefined:
  - CRC logic and the sub-module are not compiled.
  - The CRC slot emits 16'h0000.
  - Frame length and timing are unchanged.

## Structure
- Package frame_pkg holds:
  - constants FRAME_HEADER_WORD=16'hE0E0, FRAME_TAIL_WORD=16'h0E0E, CRC16_POLY=16'h1021, CRC16_INIT=16'hFFFF;
  - the state typedef tx_state_t;
  - field position constants for the 140-bit entry.
- One sub-module, crc16_word: combinational next_crc = f(crc, 16-bit word). It is instantiated only under FRAME_TX_CRC_EN and shared with the receiver's CRC checker.

## Test plan
- **Single frame:** entry N=2, channel 0x05, words 0x1234 and 0xABCD. Required stream: E0E0, E0E0, 0005, 1234, ABCD, CRC, 0E0E, 0E0E. CRC matches the software CRC-16/CCITT over {0005,1234,ABCD}. data_valid is high for exactly 8 cycles.
- **Max length, back-to-back:** two N=8 entries queued. Second fifo_r_enable is exactly 17 cycles after the first. There is one data_valid=0 gap cycle between frames.
- **Bad length:** N=0, then N=9. Required per entry: len_err one cycle at T+2, data_valid stays 0, next entry is read immediately after.
- **Reset mid-frame:** assert rst_n=0 during the DATA state. All outputs are 0 in the same cycle. After release, the block stays idle until !fifo_empty.
- **Loopback:** random N 1..8 and random channel, stream fed into the receiver. The receiver FIFO output equals the transmitted length, channel and payload, with crc_err=0 (CRC enabled build).
- **FRAME_TX_CRC_EN undefined:** the same stimulus as the single-frame scenario emits 0000 in the CRC slot with identical timing.
